// File: rtl/fetch_unit.sv
`default_nettype none
//==============================================================================
// Module   : fetch_unit
// Brief    : Single-outstanding instruction fetch FSM with ack timeout and
//            next-PC alignment checking; faults are sticky until reset.
// Revision : 1.0
//==============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcSrc,
    input  logic [31:0] pcTarget,
    input  logic        instrReady,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    input  logic        imemAck,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        instrValid,
    output logic        misalign,
    output logic        busError
);

    localparam logic [31:0] c_NOP       = 32'h0000_0013;
    // Counter value seen during the last BUSY cycle allowed before a fault.
    localparam logic [3:0]  c_WAIT_LAST = 4'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } stateT;

    stateT       r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [3:0]  r_waitCnt;
    logic        r_misalign;
    logic        r_busError;
    logic        r_imemReq;
    logic        r_instrValid;

    logic [31:0] w_pcPlus4;
    logic [31:0] w_nextPc;

    assign w_pcPlus4 = r_pc + 32'd4;
    assign w_nextPc  = pcSrc ? pcTarget : w_pcPlus4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_instr      <= c_NOP;
            r_waitCnt    <= '0;
            r_misalign   <= 1'b0;
            r_busError   <= 1'b0;
            r_imemReq    <= 1'b0;
            r_instrValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state   <= S_BUSY;
                    r_imemReq <= 1'b1;
                end
                S_BUSY: begin
                    // A late ack in the final allowed cycle still completes the fetch.
                    if (imemAck) begin
                        r_instr      <= imemData;
                        r_waitCnt    <= '0;
                        r_state      <= S_VALID;
                        r_imemReq    <= 1'b0;
                        r_instrValid <= 1'b1;
                    end else if (r_waitCnt == c_WAIT_LAST) begin
                        r_busError <= 1'b1;
                        r_instr    <= c_NOP;
                        r_state    <= S_FAULT;
                        r_imemReq  <= 1'b0;
                    end else begin
                        r_waitCnt <= r_waitCnt + 4'd1;
                    end
                end
                S_VALID: begin
                    if (instrReady) begin
                        r_pc         <= w_nextPc;
                        r_instrValid <= 1'b0;
                        if (w_nextPc[1:0] == 2'b00) begin
                            r_state   <= S_BUSY;
                            r_imemReq <= 1'b1;
                        end else begin
                            r_misalign <= 1'b1;
                            r_instr    <= c_NOP;
                            r_state    <= S_FAULT;
                        end
                    end
                end
                default: begin
                    r_imemReq    <= 1'b0;
                    r_instrValid <= 1'b0;
                end
            endcase
        end
    end

    assign imemReq    = r_imemReq;
    assign imemAddr   = r_pc;
    assign instr      = r_instr;
    assign pc         = r_pc;
    assign pcPlus4    = w_pcPlus4;
    assign instrValid = r_instrValid;
    assign misalign   = r_misalign;
    assign busError   = r_busError;

endmodule
`default_nettype wire
